// File: rtl/pipeline_control.sv
// Hazard, stall and flush controller for the 5-stage RV32I pipeline.
// Drives stage-register load/flush and PC redirect, and keeps saturating perf counters.
module pipeline_control #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic             dcache_read,
  input  logic             dcache_write,
  input  logic             dcache_resp,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             load_pc,
  output logic             pc_sel_redirect,
  output logic [WIDTH-1:0] redirect_target,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             icache_read_en,
  output logic [CW-1:0]    stall_count,
  output logic [CW-1:0]    redirect_count
);

  typedef enum logic [1:0] {
    StRun,
    StImissRedirect,
    StRedirect
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] redirect_q, redirect_d;
  logic [CW-1:0]    stall_q, redir_cnt_q;
  logic             istall, dstall;

  assign istall = icache_read & ~icache_resp;
  assign dstall = (dcache_read | dcache_write) & ~dcache_resp;

  always_comb begin
    state_d         = state_q;
    redirect_d      = redirect_q;
    load_pc         = 1'b1;
    pc_sel_redirect = 1'b0;
    redirect_target = branch_target;
    load_if_id      = 1'b1;
    load_id_ex      = 1'b1;
    load_ex_mem     = 1'b1;
    load_mem_wb     = 1'b1;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    flush_ex_mem    = 1'b0;
    icache_read_en  = 1'b1;

    unique case (state_q)
      StRun: begin
        if (branch_taken && !istall) begin
          pc_sel_redirect = 1'b1;
          flush_if_id     = 1'b1;
          flush_id_ex     = 1'b1;
          flush_ex_mem    = 1'b1;
        end else if (branch_taken) begin
          // The wrong-path fetch cannot be aborted; park the target until it returns.
          redirect_d   = branch_target;
          load_pc      = 1'b0;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          state_d      = StImissRedirect;
        end else if (load_use_hazard) begin
          load_pc     = 1'b0;
          load_if_id  = 1'b0;
          flush_id_ex = 1'b1;
        end else if (istall) begin
          load_pc     = 1'b0;
          flush_if_id = 1'b1;
        end
      end
      StImissRedirect: begin
        load_pc         = 1'b0;
        flush_if_id     = 1'b1;
        redirect_target = redirect_q;
        if (icache_resp) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        icache_read_en  = 1'b0;
        redirect_target = redirect_q;
        pc_sel_redirect = 1'b1;
        flush_if_id     = 1'b1;
        state_d         = StRun;
      end
      default: state_d = StRun;
    endcase

    // A data-cache stall freezes the whole pipe, including this controller.
    if (dstall) begin
      state_d         = state_q;
      redirect_d      = redirect_q;
      load_pc         = 1'b0;
      pc_sel_redirect = 1'b0;
      load_if_id      = 1'b0;
      load_id_ex      = 1'b0;
      load_ex_mem     = 1'b0;
      load_mem_wb     = 1'b0;
      flush_if_id     = 1'b0;
      flush_id_ex     = 1'b0;
      flush_ex_mem    = 1'b0;
    end

    if (!reset) begin
      load_pc         = 1'b0;
      pc_sel_redirect = 1'b0;
      redirect_target = '0;
      load_if_id      = 1'b0;
      load_id_ex      = 1'b0;
      load_ex_mem     = 1'b0;
      load_mem_wb     = 1'b0;
      flush_if_id     = 1'b0;
      flush_id_ex     = 1'b0;
      flush_ex_mem    = 1'b0;
      icache_read_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q     <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (!load_pc && stall_q != {CW{1'b1}}) begin
        stall_q <= stall_q + CW'(1);
      end
      if (load_pc && pc_sel_redirect && redir_cnt_q != {CW{1'b1}}) begin
        redir_cnt_q <= redir_cnt_q + CW'(1);
      end
    end
  end

  assign stall_count    = stall_q;
  assign redirect_count = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios then randomized traffic
// compared against a rule-level reference model.
module tb_pipeline_control;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CW     = 4;
  localparam int unsigned CNTMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             icache_read, icache_resp, dcache_read, dcache_write, dcache_resp;
  logic             load_use_hazard, branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             load_pc, pc_sel_redirect;
  logic [WIDTH-1:0] redirect_target;
  logic             load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic             flush_if_id, flush_id_ex, flush_ex_mem, icache_read_en;
  logic [CW-1:0]    stall_count, redirect_count;

  pipeline_control #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .icache_read     (icache_read),
    .icache_resp     (icache_resp),
    .dcache_read     (dcache_read),
    .dcache_write    (dcache_write),
    .dcache_resp     (dcache_resp),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .load_pc         (load_pc),
    .pc_sel_redirect (pc_sel_redirect),
    .redirect_target (redirect_target),
    .load_if_id      (load_if_id),
    .load_id_ex      (load_id_ex),
    .load_ex_mem     (load_ex_mem),
    .load_mem_wb     (load_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .icache_read_en  (icache_read_en),
    .stall_count     (stall_count),
    .redirect_count  (redirect_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: a pending-redirect story rather than a state register.
  bit          wrong_path_in_flight;
  bit          redirect_due;
  logic [31:0] parked_target;
  int unsigned m_stalls, m_redirects;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    wrong_path_in_flight = 1'b0;
    redirect_due         = 1'b0;
    parked_target        = '0;
    m_stalls             = 0;
    m_redirects          = 0;
  endtask

  // One clock: drive inputs, compare outputs at the falling edge, advance model at the rising edge.
  task automatic cyc(input bit rst, input bit ic_rd, input bit ic_rsp, input bit dc_rd,
                     input bit dc_wr, input bit dc_rsp, input bit lu, input bit bt,
                     input logic [31:0] tgt);
    bit          ist, dst, e_lpc, e_sel, e_ien;
    bit [3:0]    e_load;
    bit [2:0]    e_flush;
    logic [31:0] e_tgt;
    rst_n = rst; icache_read = ic_rd; icache_resp = ic_rsp; dcache_read = dc_rd;
    dcache_write = dc_wr; dcache_resp = dc_rsp; load_use_hazard = lu; branch_taken = bt;
    branch_target = tgt;
    ist = ic_rd && !ic_rsp;
    dst = (dc_rd || dc_wr) && !dc_rsp;
    if (!rst) model_reset();

    e_lpc = 1; e_sel = 0; e_load = 4'b1111; e_flush = 3'b000; e_ien = 1; e_tgt = tgt;
    if (wrong_path_in_flight) begin
      e_lpc = 0; e_flush[2] = 1; e_tgt = parked_target;
    end else if (redirect_due) begin
      e_sel = 1; e_flush[2] = 1; e_ien = 0; e_tgt = parked_target;
    end else if (bt) begin
      e_flush = 3'b111;
      if (ist) e_lpc = 0;
      else e_sel = 1;
    end else if (lu) begin
      e_lpc = 0; e_load[3] = 0; e_flush[1] = 1;
    end else if (ist) begin
      e_lpc = 0; e_flush[2] = 1;
    end
    if (dst) begin
      e_lpc = 0; e_sel = 0; e_load = '0; e_flush = '0;
    end
    if (!rst) begin
      e_lpc = 0; e_sel = 0; e_load = '0; e_flush = '0; e_ien = 0; e_tgt = '0;
    end

    @(negedge clk);
    check("ctrl", {22'd0, load_pc, pc_sel_redirect, load_if_id, load_id_ex, load_ex_mem,
                   load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, icache_read_en},
          {22'd0, e_lpc, e_sel, e_load, e_flush, e_ien});
    check("redirect_target", redirect_target, e_tgt);
    check("stall_count", {28'd0, stall_count}, m_stalls);
    check("redirect_count", {28'd0, redirect_count}, m_redirects);

    @(posedge clk);
    if (rst) begin
      if (!e_lpc && m_stalls < CNTMAX) m_stalls++;
      if (e_lpc && e_sel && m_redirects < CNTMAX) m_redirects++;
      if (!dst) begin
        if (wrong_path_in_flight) begin
          if (ic_rsp) begin
            wrong_path_in_flight = 0;
            redirect_due         = 1;
          end
        end else if (redirect_due) begin
          redirect_due = 0;
        end else if (bt && ist) begin
          wrong_path_in_flight = 1;
          parked_target        = tgt;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    model_reset();
    do_reset();
    do_reset();

    // Reset in the middle of a wrong-path fetch drops the parked target.
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'h40);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    do_reset();
    check("rst_stall_count", {28'd0, stall_count}, 32'd0);
    check("rst_redirect_count", {28'd0, redirect_count}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h1234);
    check("post_rst_redirect_count", {28'd0, redirect_count}, 32'd0);

    // D-cache read stall for three cycles, response on the fourth.
    do_reset();
    repeat (3) cyc(1, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 1, 0, 1, 0, 0, 32'h0);
    check("dstall_count", {28'd0, stall_count}, 32'd3);

    // Single-cycle load-use bubble.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h0);
    check("load_use_count", {28'd0, stall_count}, 32'd1);

    // Taken branch with no fetch stall.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    check("branch_redirects", {28'd0, redirect_count}, 32'd1);
    idle();

    // Taken branch under an I-cache miss; response after four cycles.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'h200);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 32'h0);
    check("imiss_no_redirect_yet", {28'd0, redirect_count}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("imiss_redirects", {28'd0, redirect_count}, 32'd1);
    idle();

    // Pending redirect held off by a D-cache write stall.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 32'h200);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) cyc(1, 0, 0, 0, 1, 0, 0, 0, 32'h0);
    check("held_redirects", {28'd0, redirect_count}, 32'd0);
    cyc(1, 0, 0, 0, 1, 1, 0, 0, 32'h0);
    check("released_redirects", {28'd0, redirect_count}, 32'd1);
    idle();

    // Randomized traffic; long enough for both counters to saturate.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 10, $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central hazard/stall/flush controller for the 5-stage RV32I pipeline.
- Drives the load and synchronous flush (reset) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus PC load/redirect select.
- Handles cache-miss stalls, load-use bubbles and taken-branch flushes, including a branch resolving while an I-cache miss is in flight.
- Also maintains saturating stall/redirect performance counters.

Parameters:
- WIDTH, 32, width of branch target / redirect address.
- CW, 32, width of performance counters.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- icache_read  input  1  I-cache request outstanding.
- icache_resp  input  1  I-cache response, one-cycle pulse.
- dcache_read  input  1  D-cache read outstanding (MEM stage).
- dcache_write  input  1  D-cache write outstanding (MEM stage).
- dcache_resp  input  1  D-cache response, one-cycle pulse.
- load_use_hazard  input  1  ID instruction depends on load in EX.
- branch_taken  input  1  taken branch/jump resolved in MEM.
- branch_target  input  WIDTH  target for branch_taken.
- load_pc  output  1  PC register load enable.
- pc_sel_redirect  output  1  1 = PC loads redirect_target, 0 = PC+4.
- redirect_target  output  WIDTH  redirect address.
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  stage register loads.
- flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  stage register synchronous clear (overrides load).
- icache_read_en  output  1  gate on I-cache request.
- stall_count  output  CW  cycles with load_pc=0.
- redirect_count  output  CW  accepted PC redirects.

Behaviour:
- Reset (async, reset=0): state=RUN; counters, redirect_q cleared to 0. Outputs while reset is low: all loads=0, all flushes=0, load_pc=0, pc_sel_redirect=0, icache_read_en=0, redirect_target=0. Reset mid-miss abandons any pending redirect.
- istall = icache_read & ~icache_resp.
- dstall = (dcache_read | dcache_write) & ~dcache_resp.
- dstall has top priority in every state: all loads=0, all flushes=0, load_pc=0, state holds. The branch stays in EX/MEM, so branch_taken persists.

FSM states: RUN, IMISS_REDIRECT, REDIRECT.

RUN (default, no dstall):
- Base: all loads=1, no flush, load_pc=1, pc_sel_redirect=0, icache_read_en=1, redirect_target=branch_target.
- branch_taken & ~istall:
  - load_pc=1, pc_sel_redirect=1.
  - flush_if_id=flush_id_ex=flush_ex_mem=1.
  - Stay RUN. Overrides load_use_hazard.
- branch_taken & istall:
  - redirect_q<=branch_target.
  - Flush IF/ID, ID/EX, EX/MEM; load_mem_wb=1; load_pc=0.
  - Go IMISS_REDIRECT.
- istall only: load_pc=0, flush_if_id=1 (bubble), downstream loads=1.
- load_use_hazard only (no istall): load_pc=0, load_if_id=0, flush_id_ex=1, EX/MEM and MEM/WB load=1.
- istall & load_use_hazard: load_pc=0, load_if_id=0, flush_id_ex=1, flush_if_id=0.

IMISS_REDIRECT (wrong-path fetch in flight; cannot abort):
- load_pc=0, flush_if_id=1, other loads=1, icache_read_en=1.
- On icache_resp: go REDIRECT; fetched data is discarded by flush_if_id.

REDIRECT:
- icache_read_en=0.
- If ~dstall: load_pc=1, pc_sel_redirect=1, redirect_target=redirect_q, flush_if_id=1, go RUN.
- New branch_taken cannot occur here because younger stages hold bubbles.

Counters:
- stall_count += 1 on each non-reset cycle with load_pc=0.
- redirect_count += 1 on each cycle with load_pc & pc_sel_redirect.
- Both saturate at 2^CW-1.
- Counter updates are registered: visible the cycle after the event.

Test Plan:
- Reset low mid-IMISS_REDIRECT, redirect_q=0x40 -> next cycle state RUN, all loads=0, redirect_target=0, counters=0. After release, RUN base outputs.
- dcache_read=1 for 3 cycles, resp on cycle 4 -> all loads=0 on cycles 1-3, all=1 on cycle 4; stall_count=3.
- load_use_hazard for 1 cycle -> load_pc=0, load_if_id=0, flush_id_ex=1, load_ex_mem=1; stall_count=1.
- branch_taken, branch_target=0x0000_0100, no stall -> load_pc=1, pc_sel_redirect=1, redirect_target=0x100, three flushes=1; redirect_count=1.
- branch_taken target 0x200 with istall, icache_resp 4 cycles later -> IMISS_REDIRECT for 4 cycles with flush_if_id=1, load_pc=0. REDIRECT then loads 0x200 with icache_read_en=0, then RUN; redirect_count=1.
- In REDIRECT with dcache_write stall for 2 cycles -> PC held and all loads=0; redirect to 0x200 fires only on resp cycle.
